// File: rtl/coax_rx_word_decoder_pkg.sv
// Shared coax receive constants: error codes, word-decoder state encoding and parity helper.
package coax_rx_word_decoder_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 10;
   localparam int unsigned ERR_CODE_W         = 2;
   localparam int unsigned PARITY_MAX_W       = 32;

   localparam logic [ERR_CODE_W-1:0] ERR_NONE         = 2'd0;
   localparam logic [ERR_CODE_W-1:0] ERR_PARITY       = 2'd1;
   localparam logic [ERR_CODE_W-1:0] ERR_LOSS_OF_SYNC = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HUNT   = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_SYNC   = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   // Returns 1 when the vector holds an odd number of ones; callers zero-extend.
   function automatic logic parity_of(input logic [PARITY_MAX_W-1:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/coax_rx_word_decoder.sv
// Frames the sampled coax bit stream into sync/data/parity words and flags end of message
// and receive errors as one-cycle registered pulses.
module coax_rx_word_decoder
   import coax_rx_word_decoder_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter bit          PARITY_EVEN = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx,
   input  logic                  sample,
   input  logic                  synchronized,
   output logic                  active,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  data_strobe,
   output logic                  eom,
   output logic                  error,
   output logic [ERR_CODE_W-1:0] error_code
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [DATA_WIDTH-1:0]   data_d;
   logic [ERR_CODE_W-1:0]   code_d;
   logic                    active_d, strobe_d, eom_d, error_d;
   logic                    odd_ones, parity_ok;

   assign odd_ones  = parity_of(PARITY_MAX_W'({shift_q, rx}));
   assign parity_ok = PARITY_EVEN ? ~odd_ones : odd_ones;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         shift_q     <= '0;
         active      <= 1'b0;
         data        <= '0;
         data_strobe <= 1'b0;
         eom         <= 1'b0;
         error       <= 1'b0;
         error_code  <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         shift_q     <= shift_d;
         active      <= active_d;
         data        <= data_d;
         data_strobe <= strobe_d;
         eom         <= eom_d;
         error       <= error_d;
         error_code  <= code_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      shift_d  = shift_q;
      data_d   = data;
      code_d   = error_code;
      strobe_d = 1'b0;
      eom_d    = 1'b0;
      error_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (synchronized) state_d = ST_HUNT;
         end
         ST_HUNT: begin
            if (!synchronized) begin
               state_d = ST_IDLE;
            end else if (sample && rx) begin
               state_d = ST_DATA;
               count_d = '0;
            end
         end
         ST_DATA, ST_PARITY, ST_SYNC: begin
            // Loss of lock beats any coincident sample and drops the partial word.
            if (!synchronized) begin
               state_d = ST_IDLE;
               error_d = 1'b1;
               code_d  = ERR_LOSS_OF_SYNC;
            end else if (sample) begin
               if (state_q == ST_DATA) begin
                  shift_d = {shift_q[DATA_WIDTH-2:0], rx};
                  count_d = count_q + CNT_W'(1);
                  if (count_q == CNT_W'(DATA_WIDTH - 1)) state_d = ST_PARITY;
               end else if (state_q == ST_PARITY) begin
                  state_d = ST_SYNC;
                  if (parity_ok) begin
                     data_d   = shift_q;
                     strobe_d = 1'b1;
                  end else begin
                     error_d = 1'b1;
                     code_d  = ERR_PARITY;
                  end
               end else if (rx) begin
                  state_d = ST_DATA;
                  count_d = '0;
               end else begin
                  state_d = ST_DONE;
                  eom_d   = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (!synchronized) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      active_d = (state_d == ST_DATA) || (state_d == ST_PARITY) || (state_d == ST_SYNC);
   end

endmodule

// File: tb/tb_coax_rx_word_decoder.sv
// Directed bench for coax_rx_word_decoder: emulates the bit timer's sample strobe and
// checks word strobes, end-of-message and error pulses against hand-computed values.
module tb_coax_rx_word_decoder;
   import coax_rx_word_decoder_pkg::*;

   localparam int unsigned W = 10;

   logic          clk = 1'b0;
   logic          reset, rx, sample, synchronized;
   logic          active, data_strobe, eom, error;
   logic [W-1:0]  data;
   logic [1:0]    error_code;

   int total = 0;
   int bad   = 0;
   int n_strobe = 0, n_eom = 0, n_error = 0, n_excl = 0;
   logic [W-1:0] seen[$];

   coax_rx_word_decoder #(.DATA_WIDTH(W), .PARITY_EVEN(1'b1)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx),
      .sample       (sample),
      .synchronized (synchronized),
      .active       (active),
      .data         (data),
      .data_strobe  (data_strobe),
      .eom          (eom),
      .error        (error),
      .error_code   (error_code)
   );

   always #5 clk = ~clk;

   // Pulse monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (data_strobe) begin
         n_strobe++;
         seen.push_back(data);
      end
      if (eom)   n_eom++;
      if (error) n_error++;
      if ((32'(data_strobe) + 32'(eom) + 32'(error)) > 32'd1) n_excl++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      n_strobe = 0;
      n_eom    = 0;
      n_error  = 0;
      seen.delete();
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      @(negedge clk);
      @(negedge clk);
      sample = 1'b1;
      @(negedge clk);
      sample = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic flip);
      send_bit(1'b1);
      for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
      send_bit((^w) ^ flip);
   endtask

   task automatic resync();
      synchronized = 1'b0;
      repeat (3) @(negedge clk);
      synchronized = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      logic [W-1:0] w;
      reset = 1'b1; rx = 1'b0; sample = 1'b0; synchronized = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_active", 32'(active), 32'd0);
      check_eq("rst_data", 32'(data), 32'd0);
      check_eq("rst_pulses", 32'({data_strobe, eom, error}), 32'd0);
      check_eq("rst_code", 32'(error_code), 32'd0);
      check_eq("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      reset = 1'b0;
      synchronized = 1'b1;
      repeat (3) @(negedge clk);
      clear_mon();

      // three-word message then end of message
      send_word(10'h2A5, 1'b0);
      check_eq("t1_active_mid", 32'(active), 32'd1);
      send_word(10'h000, 1'b0);
      send_word(10'h3FF, 1'b0);
      check_eq("t1_active_last", 32'(active), 32'd1);
      send_bit(1'b0);
      check_eq("t1_nstrobe", 32'(n_strobe), 32'd3);
      check_eq("t1_w0", 32'(seen[0]), 32'h2A5);
      check_eq("t1_w1", 32'(seen[1]), 32'h000);
      check_eq("t1_w2", 32'(seen[2]), 32'h3FF);
      check_eq("t1_neom", 32'(n_eom), 32'd1);
      check_eq("t1_nerr", 32'(n_error), 32'd0);
      check_eq("t1_active_end", 32'(active), 32'd0);
      check_eq("t1_state_done", 32'(dut.state_q), 32'(ST_DONE));

      // bad parity, then a good word
      resync();
      clear_mon();
      send_word(10'h155, 1'b1);
      check_eq("t2_nerr", 32'(n_error), 32'd1);
      check_eq("t2_code", 32'(error_code), 32'(ERR_PARITY));
      check_eq("t2_data_held", 32'(data), 32'h3FF);
      check_eq("t2_nstrobe0", 32'(n_strobe), 32'd0);
      check_eq("t2_active", 32'(active), 32'd1);
      send_word(10'h0F0, 1'b0);
      send_bit(1'b0);
      check_eq("t2_nstrobe", 32'(n_strobe), 32'd1);
      check_eq("t2_w0", 32'(seen[0]), 32'h0F0);
      check_eq("t2_data", 32'(data), 32'h0F0);
      check_eq("t2_neom", 32'(n_eom), 32'd1);

      // loss of sync after five data bits
      resync();
      clear_mon();
      w = 10'h155;
      send_bit(1'b1);
      for (int i = W - 1; i >= 5; i--) send_bit(w[i]);
      synchronized = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("t3_nerr", 32'(n_error), 32'd1);
      check_eq("t3_code", 32'(error_code), 32'(ERR_LOSS_OF_SYNC));
      check_eq("t3_active", 32'(active), 32'd0);
      check_eq("t3_state", 32'(dut.state_q), 32'(ST_IDLE));
      check_eq("t3_nstrobe", 32'(n_strobe), 32'd0);
      check_eq("t3_neom", 32'(n_eom), 32'd0);

      // sample coincides with synchronized falling in PARITY
      synchronized = 1'b1;
      repeat (3) @(negedge clk);
      clear_mon();
      w = 10'h2A5;
      send_bit(1'b1);
      for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
      rx = ^w;
      repeat (2) @(negedge clk);
      sample = 1'b1;
      synchronized = 1'b0;
      @(negedge clk);
      sample = 1'b0;
      @(negedge clk);
      check_eq("t4_nerr", 32'(n_error), 32'd1);
      check_eq("t4_code", 32'(error_code), 32'(ERR_LOSS_OF_SYNC));
      check_eq("t4_nstrobe", 32'(n_strobe), 32'd0);
      check_eq("t4_data", 32'(data), 32'h0F0);
      check_eq("t4_active", 32'(active), 32'd0);

      // reset mid-word with synchronized held high
      synchronized = 1'b1;
      repeat (3) @(negedge clk);
      clear_mon();
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq("t5_active", 32'(active), 32'd0);
      check_eq("t5_data", 32'(data), 32'd0);
      check_eq("t5_code", 32'(error_code), 32'd0);
      check_eq("t5_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
      check_eq("t5_pulses", 32'(n_strobe + n_eom + n_error), 32'd0);
      @(negedge clk);
      check_eq("t5_state_hunt", 32'(dut.state_q), 32'(ST_HUNT));
      send_word(10'h1C3, 1'b0);
      send_bit(1'b0);
      check_eq("t5_nstrobe", 32'(n_strobe), 32'd1);
      check_eq("t5_w0", 32'(seen[0]), 32'h1C3);
      check_eq("t5_neom", 32'(n_eom), 32'd1);

      // long preamble in HUNT
      resync();
      clear_mon();
      repeat (20) send_bit(1'b0);
      check_eq("t6_active_pre", 32'(active), 32'd0);
      send_word(10'h001, 1'b0);
      send_bit(1'b0);
      check_eq("t6_nstrobe", 32'(n_strobe), 32'd1);
      check_eq("t6_w0", 32'(seen[0]), 32'h001);
      check_eq("t6_neom", 32'(n_eom), 32'd1);
      check_eq("t6_nerr", 32'(n_error), 32'd0);

      check_eq("pulse_excl", 32'(n_excl), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
